seg_scan_rx: RTL and testbench

Receive side of the multiplexed 7-segment display bus. It samples the active-low segment lines and the active-low digit-select lines driven by the display scanner. It waits for each digit slot to be stable, then maps each segment pattern back to its 4-bit digit code and stores it per digit position. The block is used for loop-back checking of the display path and for reading an external display board.

---
 rtl/seg_scan_rx.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: receive side of a multiplexed 7-segment display bus.
// Waits for each digit slot to settle, decodes it, stores it per position.
module seg_scan_rx #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   dig_sel_n,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   valid_mask,
  output logic [NDIG-1:0]   bad_mask,
  output logic              frame_done
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]   CMAX  = CW'(STABLE);
  localparam logic [CW-1:0]   CONE  = CW'(1);
  localparam logic [NDIG-1:0] SONE  = NDIG'(1);

  typedef enum logic {
    WAIT,
    HELD
  } state_t;

  state_t state_q, state_d;

  logic [7:0]      seg_s1, seg_s2, seg_p;
  logic [NDIG-1:0] sel_s1, sel_s2, sel_p;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NDIG-1:0] seen;
  logic [NDIG-1:0] seen_set;
  logic [NDIG-1:0] sel_act;
  logic [PW-1:0]   pos;
  logic            change;
  logic            one_hot;
  logic            cap;
  logic [3:0]      code;
  logic            code_ok;
  logic            code_bad;

  // two-flop synchronizers, idle bus (all ones) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      sel_s1 <= '1;
      sel_s2 <= '1;
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      sel_s1 <= dig_sel_n;
      sel_s2 <= sel_s1;
    end
  end

  // previous synchronized sample, compared against each new one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p <= '1;
      sel_p <= '1;
    end else begin
      seg_p <= seg_s2;
      sel_p <= sel_s2;
    end
  end

  // active digit position and whether exactly one select is low
  always_comb begin
    sel_act = ~sel_p;
    one_hot = (sel_act != '0) &&
              ((sel_act & (sel_act - SONE)) == '0);
    pos     = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_act[i]) pos = PW'(i);
    end
  end

  // segment pattern back to digit code
  always_comb begin
    code     = 4'hE;
    code_ok  = 1'b0;
    code_bad = 1'b1;
    case (seg_p[6:0])
      7'h40: code = 4'd0;
      7'h79: code = 4'd1;
      7'h24: code = 4'd2;
      7'h30: code = 4'd3;
      7'h19: code = 4'd4;
      7'h12: code = 4'd5;
      7'h02: code = 4'd6;
      7'h78: code = 4'd7;
      7'h00: code = 4'd8;
      7'h10: code = 4'd9;
      7'h7F: code = 4'hF;
      default: code = 4'hE;
    endcase
    if (code <= 4'd9) begin
      code_ok  = 1'b1;
      code_bad = 1'b0;
    end else if (code == 4'hF) begin
      code_bad = 1'b0;
    end
  end

  // stability tracker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next window count/state and the one-per-window capture strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    change  = {seg_s2, sel_s2} != {seg_p, sel_p};
    if (change) begin
      cnt_d = CONE;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + CONE;
    end
    if (state_q == WAIT && cnt_q == CMAX && one_hot) begin
      cap     = 1'b1;
      state_d = HELD;
    end
    if (change) state_d = WAIT;
  end

  // positions captured in this frame, including the current one
  always_comb begin
    seen_set = seen | (SONE << pos);
  end

  // per-position result storage and frame tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits     <= '1;
      dp         <= '0;
      valid_mask <= '0;
      bad_mask   <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cap) begin
        digits[4*pos +: 4] <= code;
        dp[pos]            <= ~seg_p[7];
        valid_mask[pos]    <= code_ok;
        bad_mask[pos]      <= code_bad;
        if (&seen_set) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: scoreboard bench for seg_scan_rx.
// Expected snapshots are queued on stimulus and popped on capture.
module tb_seg_scan_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_n = 8'hFF;
  logic [3:0]  dig_sel_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  valid_mask;
  logic [3:0]  bad_mask;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int ncap = 0;
  int nfd = 0;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  val;
    logic [3:0]  bad;
    logic        fd;
  } exp_t;

  exp_t q[$];

  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_val, m_bad, m_seen;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_scan_rx #(.NDIG(4), .STABLE(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_n(seg_n),
    .dig_sel_n(dig_sel_n),
    .digits(digits),
    .dp(dp),
    .valid_mask(valid_mask),
    .bad_mask(bad_mask),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_dig  = 16'hFFFF;
    m_dp   = '0;
    m_val  = '0;
    m_bad  = '0;
    m_seen = '0;
  endtask

  task automatic push(input logic [3:0] sel, input logic [7:0] seg);
    exp_t e;
    int p;
    logic [3:0] code;
    logic v, b;
    p = 0;
    for (int i = 0; i < 4; i++) if (!sel[i]) p = i;
    code = 4'hE;
    v = 1'b0;
    b = 1'b1;
    if (seg[6:0] == 7'h7F) begin
      code = 4'hF;
      b = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      if (seg[6:0] == pat[k]) begin
        code = 4'(k);
        v = 1'b1;
        b = 1'b0;
      end
    end
    m_dig[4*p +: 4] = code;
    m_dp[p]   = ~seg[7];
    m_val[p]  = v;
    m_bad[p]  = b;
    m_seen[p] = 1'b1;
    e.fd = &m_seen;
    if (e.fd) m_seen = '0;
    e.dig = m_dig;
    e.dp  = m_dp;
    e.val = m_val;
    e.bad = m_bad;
    q.push_back(e);
  endtask

  task automatic present(input logic [3:0] sel, input logic [7:0] seg,
                         input int cyc, input bit exp);
    @(negedge clk);
    dig_sel_n = sel;
    seg_n = seg;
    if (exp) push(sel, seg);
    repeat (cyc) @(posedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dig"}, 32'(digits), 32'hFFFF);
    chk({tag, "_dp"}, 32'(dp), 32'h0);
    chk({tag, "_val"}, 32'(valid_mask), 32'h0);
    chk({tag, "_bad"}, 32'(bad_mask), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // capture monitor: compare against the oldest queued snapshot
  always @(negedge clk) begin
    if (dut.cap) begin
      exp_t e;
      ncap++;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("unexp_cap", 32'(digits), 32'hDEAD);
      end else begin
        e = q.pop_front();
        chk("cap_dig", 32'(digits), 32'(e.dig));
        chk("cap_dp", 32'(dp), 32'(e.dp));
        chk("cap_val", 32'(valid_mask), 32'(e.val));
        chk("cap_bad", 32'(bad_mask), 32'(e.bad));
        chk("cap_fd", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  // frame pulse counter
  always @(negedge clk) begin
    if (frame_done) nfd++;
  end

  initial begin
    int c0;
    m_reset();
    dig_sel_n = 4'b1110;
    seg_n = 8'hA4;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");

    @(negedge clk);
    rst_n = 1'b1;
    push(4'b1110, 8'hA4);
    repeat (6) @(posedge clk);
    #1;
    chk("lat_hold", 32'(digits), 32'hFFFF);
    chk("lat_hold_v", 32'(valid_mask), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_cap", 32'(digits), 32'hFFF2);
    chk("lat_cap_v", 32'(valid_mask), 32'h1);
    chk("lat_cap_dp", 32'(dp), 32'h0);
    repeat (5) @(posedge clk);
    chk("one_cap", 32'(ncap), 32'd1);

    present(4'b1101, 8'h99, 3, 1'b0);
    present(4'b1101, 8'hFF, 10, 1'b1);
    #1;
    chk("glitch_nib", 32'(digits[7:4]), 32'hF);
    chk("glitch_v", 32'(valid_mask[1]), 32'h0);
    chk("glitch_caps", 32'(ncap), 32'd2);

    @(negedge clk);
    rst_n = 1'b0;
    dig_sel_n = 4'hF;
    seg_n = 8'hFF;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    c0 = nfd;
    present(4'b1110, 8'hC0, 8, 1'b1);
    present(4'b1101, 8'hF9, 8, 1'b1);
    present(4'b1011, 8'h80, 8, 1'b1);
    present(4'b0111, 8'h10, 8, 1'b1);
    #1;
    chk("frame_dig", 32'(digits), 32'h9810);
    chk("frame_val", 32'(valid_mask), 32'hF);
    chk("frame_dp", 32'(dp), 32'h8);
    chk("frame_n1", 32'(nfd - c0), 32'd1);
    present(4'b1110, 8'hC0, 8, 1'b1);
    present(4'b1101, 8'hF9, 8, 1'b1);
    present(4'b1011, 8'h80, 8, 1'b1);
    present(4'b0111, 8'h10, 8, 1'b1);
    #1;
    chk("frame_n2", 32'(nfd - c0), 32'd2);

    present(4'b1011, 8'hFE, 8, 1'b1);
    #1;
    chk("ill_nib", 32'(digits[11:8]), 32'hE);
    chk("ill_bad", 32'(bad_mask[2]), 32'h1);
    present(4'b1011, 8'hFF, 8, 1'b1);
    #1;
    chk("blank_nib", 32'(digits[11:8]), 32'hF);
    chk("blank_bad", 32'(bad_mask[2]), 32'h0);
    chk("blank_val", 32'(valid_mask[2]), 32'h0);

    c0 = ncap;
    present(4'b1100, 8'hA4, 20, 1'b0);
    present(4'b1111, 8'hC0, 20, 1'b0);
    chk("sel_nocap", 32'(ncap - c0), 32'd0);

    present(4'b1011, 8'hA4, 4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    push(4'b1011, 8'hA4);
    repeat (6) @(posedge clk);
    #1;
    chk("rel_hold", 32'(digits), 32'hFFFF);
    @(posedge clk);
    #1;
    chk("rel_cap", 32'(digits), 32'hF2FF);
    chk("rel_val", 32'(valid_mask), 32'h4);

    repeat (10) @(posedge clk);
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
